// File: rtl/fp_calc_sequencer_if.sv
// Request, FPU and response signal bundle for fp_calc_sequencer.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever sits around it: the requester, the FPU and the response consumer.
interface fp_calc_sequencer_if #(
    parameter int TAG_W = 4
);
    // request port
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    // FPU side
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_op;
    logic             fpu_en;
    logic [31:0]      fpu_result;
    logic             fpu_finish;

    // response port
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  fpu_result, fpu_finish,
        input  rsp_ready,
        output req_ready,
        output fpu_a, fpu_b, fpu_op, fpu_en,
        output rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output fpu_result, fpu_finish,
        output rsp_ready,
        input  req_ready,
        input  fpu_a, fpu_b, fpu_op, fpu_en,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/fp_calc_sequencer.sv
// Front-end sequencer for the floating point calculator.
// It accepts one add/sub/mul/div at a time and drives the FPU operands.
// Add, sub and mul wait a fixed pipeline latency.
// Divide waits for the divider's finish flag, bounded by a timeout.
// The result is returned with the request tag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a request; the FPU operands hold the last op
// ISSUE     | one cycle with fpu_en high; load the wait counter
// WAIT_FIX  | add/sub/mul in flight; count down to the result cycle
// WAIT_DIV  | divide in flight, fpu_en held; finish or timeout ends it
// RESP      | response presented until the consumer takes it
module fp_calc_sequencer #(
    parameter int ADDSUB_LAT  = 2,
    parameter int MUL_LAT     = 2,
    parameter int DIV_TIMEOUT = 64,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_calc_sequencer_if.slave    bus
);

    localparam int MAX_FIX = (ADDSUB_LAT > MUL_LAT) ? ADDSUB_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_FIX > DIV_TIMEOUT) ? MAX_FIX : DIV_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_FIX = 3'd2;
    localparam logic [2:0] S_WAIT_DIV = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Quiet NaN returned when a divide is abandoned.
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             cnt_zero;
    logic             accept;

    logic [31:0]      fpu_a_q;
    logic [31:0]      fpu_b_q;
    logic [1:0]       fpu_op_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;

    assign accept   = (state == S_IDLE) && bus.req_valid;
    assign cnt_zero = (cnt == '0);

    // Pick the counter preload for the op that is being issued.
    always_comb begin
        cnt_load = CNT_W'(ADDSUB_LAT - 1);
        if (fpu_op_q == OP_MUL) begin
            cnt_load = CNT_W'(MUL_LAT - 1);
        end else if (fpu_op_q == OP_DIV) begin
            cnt_load = CNT_W'(DIV_TIMEOUT - 1);
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = (fpu_op_q == OP_DIV) ? S_WAIT_DIV : S_WAIT_FIX;
            end
            S_WAIT_FIX: begin
                if (cnt_zero) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT_DIV: begin
                if (bus.fpu_finish || cnt_zero) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and the down-counter.
    // The counter stops at zero, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_ISSUE: cnt <= cnt_load;
                S_WAIT_FIX: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WAIT_DIV: begin
                    if (!bus.fpu_finish && !cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

    // Capture the operands and tag on accept.
    // They stay on the FPU inputs until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_op_q <= '0;
            tag_q    <= '0;
        end else if (accept) begin
            fpu_a_q  <= bus.req_a;
            fpu_b_q  <= bus.req_b;
            fpu_op_q <= bus.req_op;
            tag_q    <= bus.req_tag;
        end
    end

    // Capture the result, or the timeout NaN, on the last wait cycle.
    // If finish and the timeout land in the same cycle, finish wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state == S_WAIT_FIX && cnt_zero) begin
            rsp_data_q <= bus.fpu_result;
            rsp_err_q  <= 1'b0;
        end else if (state == S_WAIT_DIV) begin
            if (bus.fpu_finish) begin
                rsp_data_q <= bus.fpu_result;
                rsp_err_q  <= 1'b0;
            end else if (cnt_zero) begin
                rsp_data_q <= QNAN;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.fpu_en    = (state == S_ISSUE) || (state == S_WAIT_DIV);
    assign bus.fpu_a     = fpu_a_q;
    assign bus.fpu_b     = fpu_b_q;
    assign bus.fpu_op    = fpu_op_q;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fp_calc_sequencer.sv
// Bench for fp_calc_sequencer.
// The FPU stub is a latency-accurate pipeline. Its result is only correct in
// the single cycle the sequencer should sample it. The divider finishes after
// a programmable number of WAIT_DIV cycles (0 = never).
module tb_fp_calc_sequencer;

    localparam int ADDSUB_LAT  = 2;
    localparam int MUL_LAT     = 3;
    localparam int DIV_TIMEOUT = 16;
    localparam int TAG_W       = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp_calc_sequencer_if #(.TAG_W(TAG_W)) bus ();

    fp_calc_sequencer #(
        .ADDSUB_LAT (ADDSUB_LAT),
        .MUL_LAT    (MUL_LAT),
        .DIV_TIMEOUT(DIV_TIMEOUT),
        .TAG_W      (TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // The stub's arithmetic is IEEE-correct for the directed vectors.
    // Otherwise it is a plain integer mix that is distinct per op.
    function automatic logic [31:0] fix_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd0 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (op == 2'd1 && a == 32'h40700000 && b == 32'h3FC00000) return 32'h40100000;
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            default: return (a * b) ^ 32'h0F0F_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
    endfunction

    // FPU stub state.
    logic [31:0] pipe [0:3];
    int          div_cnt = 0;
    int          div_delay = 0;
    logic        spur_finish = 1'b0;
    logic        stub_fin;
    logic [31:0] junk = 32'hDEAD_0000;

    always @(posedge clk) begin
        junk    <= junk + 32'h0001_0101;
        pipe[0] <= (bus.fpu_en && bus.fpu_op != 2'd3) ? fix_ref(bus.fpu_op, bus.fpu_a, bus.fpu_b) : junk;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        if (bus.fpu_en && bus.fpu_op == 2'd3) div_cnt <= div_cnt + 1;
        else div_cnt <= 0;
    end

    always_comb begin
        stub_fin       = 1'b0;
        bus.fpu_result = junk;
        if (bus.fpu_op == 2'd3) begin
            stub_fin       = bus.fpu_en && (div_delay != 0) && (div_cnt == div_delay);
            bus.fpu_result = stub_fin ? div_ref(bus.fpu_a, bus.fpu_b) : 32'hBAD0_BAD0;
        end else if (bus.fpu_op == 2'd2) begin
            bus.fpu_result = pipe[MUL_LAT-1];
        end else begin
            bus.fpu_result = pipe[ADDSUB_LAT-1];
        end
        bus.fpu_finish = stub_fin | spur_finish;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction.
    // hold = number of extra cycles with rsp_ready low while the response
    // is shown. A competing request is held valid during those cycles.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int ddelay, input int hold,
                         input logic spur);
        int          k;
        bit          ok;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        if (op == 2'd3) begin
            if (ddelay >= 1 && ddelay <= DIV_TIMEOUT) begin
                exp_lat = ddelay + 1; exp_data = div_ref(a, b); exp_err = 1'b0;
            end else begin
                exp_lat = DIV_TIMEOUT + 1; exp_data = 32'h7FC00000; exp_err = 1'b1;
            end
        end else begin
            exp_lat  = ((op == 2'd2) ? MUL_LAT : ADDSUB_LAT) + 1;
            exp_data = fix_ref(op, a, b);
            exp_err  = 1'b0;
        end
        div_delay = ddelay;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        bus.rsp_ready = (hold == 0);
        k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_op = 2'($urandom);
        spur_finish = spur && (op != 2'd3);
        chk("issue_en", 32'(bus.fpu_en), 32'd1);
        chk("issue_a", bus.fpu_a, a);
        chk("issue_b_op", {bus.fpu_b[29:0], bus.fpu_op}, {b[29:0], op});
        k = 0; ok = 1;
        while (!bus.rsp_valid && k < DIV_TIMEOUT + 20) begin
            @(negedge clk); k++;
            if (!bus.rsp_valid)
                ok &= (bus.fpu_en == (op == 2'd3)) && !bus.req_ready && (bus.fpu_a == a);
        end
        chk("latency", 32'(k), 32'(exp_lat));
        chk("wait_signals", 32'(ok), 32'd1);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_tag_err", {27'd0, bus.rsp_err, bus.rsp_tag}, {27'd0, exp_err, tag});
        ok = 1;
        if (hold > 0) begin
            bus.req_valid = 1'b1; bus.req_op = 2'($urandom); bus.req_a = $urandom; bus.req_tag = 4'($urandom);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                ok &= bus.rsp_valid && (bus.rsp_data == exp_data) && (bus.rsp_tag == tag) &&
                      (bus.rsp_err == exp_err) && !bus.req_ready && (bus.fpu_a == a);
            end
            chk("hold_stable", 32'(ok), 32'd1);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        spur_finish   = 1'b0;
        chk("after_handshake", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
    endtask

    initial begin
        bit ok;
        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("reset_ready_valid_en", {29'd0, bus.req_ready, bus.rsp_valid, bus.fpu_en}, 32'b100);
        chk("reset_fpu_a_b", bus.fpu_a | bus.fpu_b, 32'd0);
        chk("reset_rsp", {bus.rsp_data[27:0], bus.rsp_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed: add, stalled sub followed by mul, divides
        do_op(2'd0, 32'h3FC00000, 32'h40100000, 4'd3, 0, 0, 1'b0);
        do_op(2'd1, 32'h40700000, 32'h3FC00000, 4'd5, 0, 3, 1'b1);
        do_op(2'd2, 32'h40000000, 32'h40400000, 4'd6, 0, 0, 1'b0);
        do_op(2'd3, 32'h40C00000, 32'h40000000, 4'd7, 7, 0, 1'b0);
        do_op(2'd3, 32'h40C00000, 32'h40000000, 4'd8, 0, 0, 1'b0);
        do_op(2'd3, 32'h40C00000, 32'h40000000, 4'd9, DIV_TIMEOUT, 0, 1'b0);
        do_op(2'd3, 32'h11111111, 32'h22222222, 4'd10, DIV_TIMEOUT + 1, 0, 1'b0);
        do_op(2'd3, 32'h33333333, 32'h44444444, 4'd11, 1, 0, 1'b0);
        do_op(2'd0, 32'h12345678, 32'h0000FFFF, 4'd12, 0, 5, 1'b0);

        // reset while a divide is in flight
        div_delay = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'd3; bus.req_a = 32'hCAFEF00D; bus.req_b = 32'h1;
        bus.req_tag = 4'd13; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_div_en", 32'(bus.fpu_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ready_valid_en", {29'd0, bus.req_ready, bus.rsp_valid, bus.fpu_en}, 32'b100);
        chk("midreset_fpu", bus.fpu_a | bus.fpu_b | {30'd0, bus.fpu_op}, 32'd0);
        chk("midreset_rsp", bus.rsp_data | {27'd0, bus.rsp_err, bus.rsp_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1;
        repeat (DIV_TIMEOUT + 5) begin
            @(negedge clk);
            ok &= !bus.rsp_valid && bus.req_ready;
        end
        chk("no_rsp_after_reset", 32'(ok), 32'd1);
        do_op(2'd0, 32'h3FC00000, 32'h40100000, 4'd14, 0, 0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            do_op(op, $urandom, $urandom, 4'($urandom), $urandom_range(0, DIV_TIMEOUT + 2),
                  $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
